sha256_chain_core: RTL and testbench

//  Iterative SHA-256 compression engine with multi-block chaining and valid/ready handshakes.

---
 rtl/sha256_chain_core.sv | 160 ++++++++++++++++
 tb/tb_sha256_chain_core.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_chain_core.sv
// Purpose: iterative SHA-256 compression with message chaining over first/last framed 512-bit blocks.
// Latency: accept edge to out_valid = 64/UNROLL + 1 cycles; non-last block throughput 64/UNROLL + 2.
// Backpressure: in_ready only in IDLE; a digest is held in DONE until out_ready, then one IDLE cycle.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid/in_ready           block handshake; in_block word 0 = bits [511:480]
//   in_first/in_last            message framing flags, sampled with the block
//   H_init                      external IV, used for first blocks when USE_EXT_IV=1
//   out_valid/out_ready         digest handshake; out_digest H0 in bits [255:224]
//   busy                        high whenever the engine is not in IDLE
module sha256_chain_core #(
  parameter int UNROLL     = 1,
  parameter bit USE_EXT_IV = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
  input  logic [255:0] H_init,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  // Ascending packed ranges so element 0 lands in the most significant word.
  typedef logic [0:7][31:0]  hash_t;
  typedef logic [0:15][31:0] sched_t;

  localparam hash_t SHA_IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t       state_q, state_d;
  sched_t       w_q, w_d;        // w_q[0] is W[t]; window holds W[t..t+15]
  hash_t        v_q, v_d;        // working variables a..h
  hash_t        chain_q, chain_d;
  logic [255:0] dig_q, dig_d;
  logic [6:0]   t_q, t_d;
  logic         last_q, last_d;

  hash_t        iv_sel;
  assign iv_sel = USE_EXT_IV ? hash_t'(H_init) : SHA_IV;

  always_comb begin : next_state
    logic [31:0] t1, t2, wn;
    t1      = '0;
    t2      = '0;
    wn      = '0;
    state_d = state_q;
    w_d     = w_q;
    v_d     = v_q;
    chain_d = chain_q;
    dig_d   = dig_q;
    t_d     = t_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          w_d    = sched_t'(in_block);
          last_d = in_last;
          if (in_first) begin
            v_d     = iv_sel;
            chain_d = iv_sel;
          end else begin
            v_d = chain_q;
          end
          t_d     = '0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        for (int j = 0; j < UNROLL; j++) begin
          t1 = v_d[7] + bsig1(v_d[4]) + ((v_d[4] & v_d[5]) ^ (~v_d[4] & v_d[6]))
             + K[t_q[5:0] + 6'(j)] + w_d[0];
          t2 = bsig0(v_d[0]) + ((v_d[0] & v_d[1]) ^ (v_d[0] & v_d[2]) ^ (v_d[1] & v_d[2]));
          // Extend the schedule one word; on the final rounds this word is never consumed.
          wn  = ssig1(w_d[14]) + w_d[9] + ssig0(w_d[1]) + w_d[0];
          v_d = {t1 + t2, v_d[0], v_d[1], v_d[2], v_d[3] + t1, v_d[4], v_d[5], v_d[6]};
          w_d = {w_d[1:15], wn};
        end
        t_d = t_q + 7'(UNROLL);
        if (t_d == 7'd64) state_d = FINAL;
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) chain_d[i] = chain_q[i] + v_q[i];
        if (last_q) begin
          dig_d   = chain_d;
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w_q     <= '0;
      v_q     <= '0;
      chain_q <= SHA_IV;
      dig_q   <= '0;
      t_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      v_q     <= v_d;
      chain_q <= chain_d;
      dig_q   <= dig_d;
      t_q     <= t_d;
      last_q  <= last_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_digest = dig_q;

endmodule

// File: tb/tb_sha256_chain_core.sv
// Bench for sha256_chain_core: five instances (UNROLL 1/2/4/8, plus UNROLL 4 with external IV)
// driven one after another from directed vectors. A message-level SHA-256 model and a
// cycle-timing model predict every output on every falling edge.
module tb_sha256_chain_core;

  localparam int NI = 5;
  localparam int UL  [NI] = '{1, 2, 4, 8, 4};
  localparam bit EXT [NI] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam int LAT [NI] = '{65, 33, 17, 9, 17};

  localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic         iv   [NI];
  logic         fi   [NI];
  logic         la   [NI];
  logic         ordy [NI];
  logic         rstn [NI];
  logic [511:0] blk  [NI];
  logic [255:0] hin  [NI];
  logic         rdy  [NI];
  logic         ov   [NI];
  logic         bsy  [NI];
  logic [255:0] dig  [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sha256_chain_core #(.UNROLL(UL[g]), .USE_EXT_IV(EXT[g])) u_dut (
      .clk        (clk),
      .rst_n      (rstn[g]),
      .in_valid   (iv[g]),
      .in_ready   (rdy[g]),
      .in_block   (blk[g]),
      .in_first   (fi[g]),
      .in_last    (la[g]),
      .H_init     (hin[g]),
      .out_valid  (ov[g]),
      .out_ready  (ordy[g]),
      .out_digest (dig[g]),
      .busy       (bsy[g])
    );
  end

  // Straight textbook compression: full 64-word schedule, no rolling window.
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] b);
    logic [31:0] w [64];
    logic [31:0] s [8];
    logic [31:0] hv [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) begin
      hv[i] = h[255 - 32*i -: 32];
      s[i]  = hv[i];
    end
    for (int i = 0; i < 64; i++) begin
      t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[i] + w[i];
      t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[i] + s[i];
    return r;
  endfunction

  // Per-instance model state: chain value, cycle through which in_ready stays low,
  // pending digest and the cycle it must appear, and the value out_digest holds otherwise.
  logic [255:0] m_chain [NI];
  logic [255:0] m_dig   [NI];
  logic [255:0] m_hold  [NI];
  logic         m_ovp   [NI];
  int           m_ovs   [NI];
  int           m_bend  [NI];

  always @(negedge clk) begin
    logic [258:0] e, a;
    logic         eov, erdy;
    logic [255:0] base;
    for (int i = 0; i < NI; i++) begin
      if (!rstn[i]) begin
        m_chain[i] = IV;
        m_hold[i]  = '0;
        m_ovp[i]   = 1'b0;
        m_bend[i]  = -1;
        eov  = 1'b0;
        erdy = 1'b1;
        e = {1'b1, 1'b0, 1'b0, 256'h0};
      end else begin
        eov  = m_ovp[i] && (cyc >= m_ovs[i]);
        erdy = (cyc > m_bend[i]) && !eov;
        e = {erdy, eov, !erdy, eov ? m_dig[i] : m_hold[i]};
      end
      a = {rdy[i], ov[i], bsy[i], dig[i]};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs inst%0d cyc%0d rdy/ov/busy/dig got %b%b%b %h want %b%b%b %h",
                 i, cyc, a[258], a[257], a[256], a[255:0], e[258], e[257], e[256], e[255:0]);
      end
      if (rstn[i]) begin
        if (iv[i] && erdy) begin
          base = fi[i] ? (EXT[i] ? hin[i] : IV) : m_chain[i];
          m_chain[i] = compress(base, blk[i]);
          m_bend[i]  = cyc + 1 + 64 / UL[i];
          if (la[i]) begin
            m_ovp[i] = 1'b1;
            m_ovs[i] = cyc + 64 / UL[i] + 2;
            m_dig[i] = m_chain[i];
          end
        end
        if (eov && ordy[i]) begin
          m_ovp[i]  = 1'b0;
          m_hold[i] = m_dig[i];
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Called and returns at posedge+1. Returns the cycle stamp of the accept edge.
  task automatic send(input int id, input logic [511:0] b, input logic f, input logic l, output int acc);
    int n;
    n = 0;
    iv[id] = 1'b1; blk[id] = b; fi[id] = f; la[id] = l;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[id] && n < 300);
    if (!rdy[id]) begin
      checks++; errors++;
      $display("FAIL accept_timeout inst%0d got in_ready 0 want 1", id);
    end
    @(posedge clk); #1;
    acc = cyc;
    iv[id] = 1'b0;
    blk[id] = {16{32'($urandom)}};
    fi[id] = 1'($urandom); la[id] = 1'($urandom);
  endtask

  task automatic get(input int id, input int hold, output logic [255:0] d, output int ovc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov[id] && n < 300);
    ovc = cyc;
    d = dig[id];
    if (!ov[id]) begin
      checks++; errors++;
      $display("FAIL digest_timeout inst%0d got out_valid 0 want 1", id);
    end
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_digest", dig[id], d);
      chk("hold_rdy_ov", {254'h0, rdy[id], ov[id]}, 256'h1);
    end
    @(posedge clk); #1 ordy[id] = 1'b1;
    @(posedge clk); #1 ordy[id] = 1'b0;
  endtask

  task automatic run_std(input int id, input int hold);
    logic [255:0] d;
    int acc, ovc;
    send(id, B_ABC, 1'b1, 1'b1, acc);
    get(id, hold, d, ovc);
    chk($sformatf("abc_u%0d", UL[id]), d, D_ABC);
    chk($sformatf("latency_u%0d", UL[id]), 256'(ovc - acc), 256'(LAT[id]));
    send(id, B_ABC, 1'b1, 1'b1, acc);
    get(id, 0, d, ovc);
    chk("abc_after_handoff", d, D_ABC);
    send(id, B_EMPTY, 1'b1, 1'b1, acc);
    get(id, 0, d, ovc);
    chk($sformatf("empty_u%0d", UL[id]), d, D_EMPTY);
    send(id, B_TWO1, 1'b1, 1'b0, acc);
    send(id, B_TWO2, 1'b0, 1'b1, acc);
    get(id, 0, d, ovc);
    chk($sformatf("two_block_u%0d", UL[id]), d, D_TWO);
    send(id, B_TWO1, 1'b1, 1'b0, acc);
    send(id, B_ABC, 1'b1, 1'b1, acc);
    get(id, 0, d, ovc);
    chk("restart_mid_msg", d, D_ABC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d, mid;
    int acc, ovc;
    for (int i = 0; i < NI; i++) begin
      rstn[i] = 1'b0; iv[i] = 1'b0; fi[i] = 1'b0; la[i] = 1'b0; ordy[i] = 1'b0;
      blk[i] = '0; hin[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rstn[i] = 1'b1;

    // Pin the reference model to published digests.
    chk("model_abc", compress(IV, B_ABC), D_ABC);
    chk("model_empty", compress(IV, B_EMPTY), D_EMPTY);
    mid = compress(IV, B_TWO1);
    chk("model_two", compress(mid, B_TWO2), D_TWO);

    run_std(0, 20);

    // Reset after round 30 of the first block, then a non-first "abc" must chain from the IV.
    send(0, B_TWO1, 1'b1, 1'b0, acc);
    repeat (30) @(posedge clk);
    #1 rstn[0] = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {rdy[0], ov[0], bsy[0], dig[0][252:0]}, {1'b1, 1'b0, 1'b0, 253'h0});
    @(posedge clk); #1 rstn[0] = 1'b1;
    send(0, B_ABC, 1'b0, 1'b1, acc);
    get(0, 0, d, ovc);
    chk("abc_after_reset", d, D_ABC);

    for (int id = 1; id < 4; id++) run_std(id, 0);

    // External IV instance: standard IV gives "abc"; the mid-chain value finishes the two-block message.
    hin[4] = IV;
    send(4, B_ABC, 1'b1, 1'b1, acc);
    hin[4] = {8{32'($urandom)}};
    get(4, 0, d, ovc);
    chk("ext_iv_abc", d, D_ABC);
    chk("ext_iv_latency", 256'(ovc - acc), 256'(LAT[4]));
    hin[4] = mid;
    send(4, B_TWO2, 1'b1, 1'b1, acc);
    hin[4] = {8{32'($urandom)}};
    get(4, 0, d, ovc);
    chk("ext_iv_two_block", d, D_TWO);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
